// File: rtl/alu_128bit_ex.sv
// 128-bit registered ALU: arithmetic group (mode=0) and logic group (mode=1), one-cycle latency.
// Optional signed saturation of ADD/SUB/INC/DEC/NEG when ALU128BIT_EX_SATURATE_EN is defined.
module alu_128bit_ex (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] op1,
   input  logic [127:0] op2,
   input  logic [2:0]   operation,
   input  logic         mode,
   output logic [127:0] out,
   output logic         carry_flag,
   output logic         zero_flag,
   output logic         overflow_flag,
   output logic         sign_flag
);

   localparam logic [127:0] SMAX = {1'b0, {127{1'b1}}};
   localparam logic [127:0] SMIN = {1'b1, {127{1'b0}}};
   localparam logic [127:0] ONE  = 128'd1;

   logic [127:0] a;
   logic [127:0] b;
   logic         is_sub;
   logic [128:0] sum;
   logic         add_ovf;
   logic [127:0] res;
   logic         res_carry;
   logic         res_ovf;
   logic         hold_out;

   // Select adder operands; NEG is treated as 0 - op1 so borrow/overflow rules stay uniform.
   always_comb begin
      a      = op1;
      b      = op2;
      is_sub = 1'b0;
      unique case (operation)
         3'b000: begin b = op2; is_sub = 1'b0; end
         3'b001: begin b = op2; is_sub = 1'b1; end
         3'b010: begin b = ONE; is_sub = 1'b0; end
         3'b011: begin b = ONE; is_sub = 1'b1; end
         3'b100: begin a = '0; b = op1; is_sub = 1'b1; end
         3'b101: begin b = op2; is_sub = 1'b1; end
         default: begin a = op1; b = op2; is_sub = 1'b0; end
      endcase
   end

   assign sum = is_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
   assign add_ovf = is_sub ? ((a[127] != b[127]) && (sum[127] != a[127]))
                           : ((a[127] == b[127]) && (sum[127] != a[127]));

   always_comb begin
      res       = '0;
      res_carry = 1'b0;
      res_ovf   = 1'b0;
      hold_out  = 1'b0;
      if (mode == 1'b0) begin
         unique case (operation)
            3'b110: begin
               res       = {op1[126:0], 1'b0};
               res_carry = op1[127];
               res_ovf   = op1[127] ^ op1[126];
            end
            3'b111: begin
               res       = {op1[127], op1[127:1]};
               res_carry = op1[0];
               res_ovf   = 1'b0;
            end
            default: begin
               res       = sum[127:0];
               res_carry = sum[128];
               res_ovf   = add_ovf;
               hold_out  = (operation == 3'b101);
`ifdef ALU128BIT_EX_SATURATE_EN
               // Positive minuend/addend sign means the true result overflowed upward.
               if (add_ovf && (operation != 3'b101))
                  res = a[127] ? SMIN : SMAX;
`endif
            end
         endcase
      end else begin
         unique case (operation)
            3'b000:  res = op1 & op2;
            3'b001:  res = op1 | op2;
            3'b010:  res = op1 ^ op2;
            3'b011:  res = ~op1;
            3'b100:  res = ~(op1 & op2);
            3'b101:  res = ~(op1 | op2);
            3'b110:  res = ~(op1 ^ op2);
            default: res = op1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out           <= '0;
         carry_flag    <= 1'b0;
         zero_flag     <= 1'b0;
         overflow_flag <= 1'b0;
         sign_flag     <= 1'b0;
      end else begin
         if (!hold_out)
            out <= res;
         carry_flag    <= res_carry;
         zero_flag     <= (res == '0);
         overflow_flag <= res_ovf;
         sign_flag     <= res[127];
      end
   end

endmodule

// File: tb/tb_alu_128bit_ex.sv
// Directed self-checking bench for alu_128bit_ex; flags are compared packed as {carry, zero, overflow, sign}.
// Expectations follow ALU128BIT_EX_SATURATE_EN when it is defined for the build.
module tb_alu_128bit_ex;

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] SMAX = {1'b0, {127{1'b1}}};
   localparam logic [127:0] SMIN = {1'b1, {127{1'b0}}};

   logic         clk;
   logic         rst_n;
   logic [127:0] op1;
   logic [127:0] op2;
   logic [2:0]   operation;
   logic         mode;
   logic [127:0] out;
   logic         carry_flag;
   logic         zero_flag;
   logic         overflow_flag;
   logic         sign_flag;

   int total = 0;
   int bad   = 0;

   alu_128bit_ex dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op1           (op1),
      .op2           (op2),
      .operation     (operation),
      .mode          (mode),
      .out           (out),
      .carry_flag    (carry_flag),
      .zero_flag     (zero_flag),
      .overflow_flag (overflow_flag),
      .sign_flag     (sign_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply(input logic m, input logic [2:0] op, input logic [127:0] a, input logic [127:0] b);
      @(negedge clk);
      mode      = m;
      operation = op;
      op1       = a;
      op2       = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] exp_out, input logic [3:0] exp_flags);
      logic [3:0] obs_flags;
      obs_flags = {carry_flag, zero_flag, overflow_flag, sign_flag};
      total++;
      assert (out === exp_out)
      else begin
         bad++;
         $error("FAIL %s out: observed=%h expected=%h", tag, out, exp_out);
      end
      total++;
      assert (obs_flags === exp_flags)
      else begin
         bad++;
         $error("FAIL %s flags(czos): observed=%b expected=%b", tag, obs_flags, exp_flags);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      op1       = '0;
      op2       = '0;
      operation = 3'b000;
      mode      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", '0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      apply(1'b0, 3'b000, 128'd1, 128'd1);
      check("add_1_1", 128'd2, 4'b0000);
      apply(1'b0, 3'b000, ONES, 128'd1);
      check("add_wrap", '0, 4'b1100);
      apply(1'b0, 3'b000, SMAX, 128'd1);
`ifdef ALU128BIT_EX_SATURATE_EN
      check("add_ovf", SMAX, 4'b0010);
`else
      check("add_ovf", SMIN, 4'b0011);
`endif
      apply(1'b0, 3'b011, 128'd0, 128'd0);
      check("dec_0", ONES, 4'b1001);
      apply(1'b0, 3'b101, 128'd5, 128'd5);
      check("cmp_eq", ONES, 4'b0100);
      apply(1'b1, 3'b101, 128'd1, 128'd0);
      check("nor", {{127{1'b1}}, 1'b0}, 4'b0001);
      apply(1'b1, 3'b010, 128'hA5, 128'hA5);
      check("xor_same", '0, 4'b0100);
      apply(1'b0, 3'b001, 128'd3, 128'd5);
      check("sub_borrow", {{127{1'b1}}, 1'b0}, 4'b1001);
      apply(1'b0, 3'b001, SMIN, 128'd1);
`ifdef ALU128BIT_EX_SATURATE_EN
      check("sub_ovf", SMIN, 4'b0011);
`else
      check("sub_ovf", SMAX, 4'b0010);
`endif
      apply(1'b0, 3'b100, SMIN, 128'd0);
`ifdef ALU128BIT_EX_SATURATE_EN
      check("neg_min", SMAX, 4'b1010);
`else
      check("neg_min", SMIN, 4'b1011);
`endif
      apply(1'b0, 3'b100, 128'd1, 128'd0);
      check("neg_1", ONES, 4'b1001);
      apply(1'b0, 3'b010, ONES, 128'd0);
      check("inc_wrap", '0, 4'b1100);
      apply(1'b0, 3'b110, {2'b11, 125'd0, 1'b1}, 128'd0);
      check("shl", {1'b1, 125'd0, 2'b10}, 4'b1001);
      apply(1'b0, 3'b111, {1'b1, 125'd0, 2'b11}, 128'd0);
      check("sar", {2'b11, 125'd0, 1'b1}, 4'b1001);
      apply(1'b1, 3'b000, 128'hF0, 128'h3C);
      check("and", 128'h30, 4'b0000);
      apply(1'b1, 3'b001, 128'hF0, 128'h0F);
      check("or", 128'hFF, 4'b0000);
      apply(1'b1, 3'b011, 128'd0, 128'd7);
      check("not", ONES, 4'b0001);
      apply(1'b1, 3'b100, ONES, ONES);
      check("nand", '0, 4'b0100);
      apply(1'b1, 3'b110, 128'd0, 128'd0);
      check("xnor", ONES, 4'b0001);
      apply(1'b1, 3'b111, 128'h1234, 128'hFFFF);
      check("pass", 128'h1234, 4'b0000);
      apply(1'b0, 3'b101, 128'd3, 128'd5);
      check("cmp_lt", 128'h1234, 4'b1001);

      // Asynchronous reset between edges: outputs clear before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", '0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b0, 3'b000, 128'd1, 128'd1);
      check("after_reset", 128'd2, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
